// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, k_len width and drain length helper for systolic_ctrl
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READOUT, DONE} ctrl_state_t;
  localparam int K_W = $clog2(256 + 1);
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction
endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: host command, operand buffer, PE control and result handshake bundle
interface systolic_ctrl_if import systolic_pkg::*; #(
  parameter int COLS = 4,
  parameter int ADDR_W = 8,
  parameter int KW = K_W,
  parameter int CW = COLS > 1 ? $clog2(COLS) : 1
) ();
  logic start;
  logic [KW-1:0] k_len;
  logic busy;
  logic done;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic op_valid;
  logic pe_clear;
  logic pe_load;
  logic [COLS-1:0] pe_carry_en;
  logic out_valid;
  logic out_ready;
  logic [CW-1:0] out_col;
  logic [31:0] perf_cycles;
  modport master (
    input start, k_len, out_ready,
    output busy, done, rd_en, rd_addr, op_valid, pe_clear, pe_load, pe_carry_en, out_valid, out_col, perf_cycles
  );
  modport slave (
    output start, k_len, out_ready,
    input busy, done, rd_en, rd_addr, op_valid, pe_clear, pe_load, pe_carry_en, out_valid, out_col, perf_cycles
  );
endinterface

// File: rtl/systolic_ctrl_carry_mask_gen.sv
// carry_mask_gen: column index to thermometer mask with bits above the index set
module carry_mask_gen #(
  parameter int COLS = 4,
  parameter int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic [CW-1:0]   col,
  output logic [COLS-1:0] mask
);
  for (genvar j = 0; j < COLS; j++) begin : g_bit
    assign mask[j] = CW'(j) > col;
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clear/feed/drain/readout sequencer for a systolic MAC array (SYSTOLIC_CTRL_PERF_EN adds a job cycle counter)
module systolic_ctrl import systolic_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KMAX = 256,
  parameter int ADDR_W = 8
) (
  input logic clock,
  input logic reset,
  systolic_ctrl_if.master bus
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int DW = $clog2(drain_cycles(ROWS, COLS) + 1);
  localparam int XW = (KW > ADDR_W ? KW : ADDR_W) + 1;
  ctrl_state_t st;
  logic [KW-1:0] k_q;
  logic [DW-1:0] d_cnt;
  logic [CW-1:0] col_nxt;
  logic [COLS-1:0] mask;
  logic xfer, last_addr, last_drain, last_col;
  always_comb begin
    xfer = bus.out_valid && bus.out_ready;
    last_addr = XW'(bus.rd_addr) + XW'(1) == XW'(k_q);
    last_drain = d_cnt == DW'(drain_cycles(ROWS, COLS) - 1);
    last_col = bus.out_col == CW'(COLS - 1);
    col_nxt = st != READOUT || (xfer && last_col) ? '0 : xfer ? bus.out_col + CW'(1) : bus.out_col;
  end
  carry_mask_gen #(.COLS(COLS), .CW(CW)) u_mask (.col(col_nxt), .mask(mask));
  always_ff @(posedge clock) begin
    bus.op_valid <= bus.rd_en;
    if (reset) begin
      st <= IDLE;
      k_q <= '0;
      d_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.rd_en <= 1'b0;
      bus.rd_addr <= '0;
      bus.op_valid <= 1'b0;
      bus.pe_clear <= 1'b0;
      bus.pe_load <= 1'b1;
      bus.pe_carry_en <= '0;
      bus.out_valid <= 1'b0;
      bus.out_col <= '0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          st <= CLEAR;
          k_q <= bus.k_len > KW'(KMAX) ? KW'(KMAX) : bus.k_len;
          bus.busy <= 1'b1;
          bus.pe_clear <= 1'b1;
          bus.pe_load <= 1'b0;
        end
        CLEAR: begin
          st <= k_q == '0 ? DRAIN : FEED;
          bus.pe_clear <= 1'b0;
          bus.rd_en <= k_q != '0;
          d_cnt <= '0;
        end
        FEED: if (last_addr) begin
          st <= DRAIN;
          bus.rd_en <= 1'b0;
          bus.rd_addr <= '0;
        end else bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
        DRAIN: if (last_drain) begin
          st <= READOUT;
          bus.out_valid <= 1'b1;
          bus.pe_load <= 1'b1;
          bus.pe_carry_en <= mask;
          bus.out_col <= col_nxt;
        end else d_cnt <= d_cnt + DW'(1);
        READOUT: begin
          bus.out_col <= col_nxt;
          bus.pe_carry_en <= xfer && last_col ? '0 : mask;
          if (xfer && last_col) begin
            st <= DONE;
            bus.out_valid <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          st <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) bus.perf_cycles <= '0;
    else if (st == IDLE && bus.start) bus.perf_cycles <= 32'd1;
    else if (st != IDLE && st != DONE && bus.perf_cycles != '1) bus.perf_cycles <= bus.perf_cycles + 32'd1;
  end
`else
  assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed self-checking bench for systolic_ctrl
module tb_systolic_ctrl;
`ifdef SYSTOLIC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  systolic_ctrl_if #(.COLS(4), .ADDR_W(8), .KW(9), .CW(2)) bus ();
  systolic_ctrl #(.ROWS(4), .COLS(4), .KMAX(256), .ADDR_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_cycle(input int k, input int c);
    int r;
    int d;
    bit ov;
    bit re;
    logic [3:0] m;
    logic [12:0] e;
    r = k + 9;
    d = k + 13;
    ov = c >= r && c <= r + 3;
    re = c >= 2 && c <= k + 1;
    m = ov ? 4'(4'b1110 << (c - r)) : 4'b0000;
    e = {c >= 1 && c <= d, c == d, re, c >= 3 && c <= k + 2, c == 1, !(c >= 1 && c < r), ov, m, ov ? 2'(c - r) : 2'd0};
    chk($sformatf("ctrl k=%0d c=%0d", k, c),
        {19'd0, bus.busy, bus.done, bus.rd_en, bus.op_valid, bus.pe_clear, bus.pe_load, bus.out_valid, bus.pe_carry_en, bus.out_col},
        {19'd0, e});
    chk($sformatf("rd_addr k=%0d c=%0d", k, c), {24'd0, bus.rd_addr}, re ? 32'(c - 2) : 32'd0);
  endtask
  task automatic run_job(input int klen, input int k);
    bus.k_len = 9'(klen);
    bus.start = 1'b1;
    for (int c = 1; c <= k + 14; c++) begin
      step();
      bus.start = 1'b0;
      check_cycle(k, c);
      chk($sformatf("perf k=%0d c=%0d", k, c), bus.perf_cycles, PERF ? 32'(c < k + 13 ? c : k + 13) : 32'd0);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check_cycle(8, 0);
    chk("perf_reset", bus.perf_cycles, 32'd0);
    reset = 1'b0;
    step();
    check_cycle(8, 0);
    run_job(8, 8);
    repeat (3) step();
    chk("perf_hold", bus.perf_cycles, PERF ? 32'd21 : 32'd0);
    run_job(0, 0);
    run_job(300, 256);
    run_job(1, 1);
    bus.k_len = 9'd8;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (16) step();
    chk("bp_col0", {30'd0, bus.out_col}, 32'd0);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_stall%0d", i), {26'd0, bus.out_valid, bus.pe_load, bus.pe_carry_en, bus.out_col[0]}, {26'd0, 1'b1, 1'b1, 4'b1100, 1'b1});
      step();
    end
    bus.out_ready = 1'b1;
    chk("bp_col1_resume", {30'd0, bus.out_col}, 32'd1);
    step();
    chk("bp_col2", {30'd0, bus.out_col}, 32'd2);
    step();
    chk("bp_col3", {29'd0, bus.done, bus.out_col}, {29'd0, 1'b0, 2'd3});
    step();
    chk("bp_done_c26", {30'd0, bus.done, bus.out_valid}, {30'd0, 1'b1, 1'b0});
    step();
    chk("bp_idle", {30'd0, bus.busy, bus.done}, 32'd0);
    bus.k_len = 9'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.k_len = 9'd5;
    step();
    bus.start = 1'b0;
    chk("bs_feed_ignored", {28'd0, bus.busy, bus.rd_en, bus.pe_clear, bus.rd_addr[0]}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b1});
    repeat (12) step();
    chk("bs_done_c15", {31'd0, bus.done}, 32'd1);
    bus.k_len = 9'd8;
    bus.start = 1'b1;
    step();
    chk("bs_done_ignored", {30'd0, bus.busy, bus.pe_clear}, 32'd0);
    step();
    bus.start = 1'b0;
    chk("bs_idle_accepted", {30'd0, bus.busy, bus.pe_clear}, 32'd3);
    repeat (5) step();
    chk("rst_pre", {23'd0, bus.rd_en, bus.rd_addr}, {23'd0, 1'b1, 8'd4});
    reset = 1'b1;
    step();
    chk("rst_idle", {20'd0, bus.pe_load, bus.busy, bus.rd_en, bus.pe_clear, bus.rd_addr}, {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    reset = 1'b0;
    step();
    check_cycle(8, 0);
    run_job(2, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for a ROWS×COLS systolic array of multiply-accumulate PEs. It accepts a matrix-multiply command with inner dimension `k_len` and runs the job in order:

- clears the accumulators,
- streams `k_len` operand addresses to the data/weight buffers,
- flushes the array's diagonal skew with zero operands,
- drains the accumulated results one column per handshake through the PE result-carry chain.

It sits between the host command interface and the PE array plus its operand buffers, and is the only driver of the array's clear/load/carry-enable controls.

## Interface
Parameters:
- `ROWS`, 4, PE rows in the array
- `COLS`, 4, PE columns in the array
- `KMAX`, 256, largest legal `k_len`
- `ADDR_W`, 8, operand buffer address width, ≥ clog2(KMAX)

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `k_len`  in  clog2(KMAX+1)  inner dimension; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse after the last column transfer
- `rd_en`  out  1  operand buffer read strobe
- `rd_addr`  out  ADDR_W  operand index k (A column k / B row k)
- `op_valid`  out  1  `rd_en` delayed 1 cycle; array edge muxes force zero operands when low
- `pe_clear`  out  1  broadcast accumulator clear
- `pe_load`  out  1  broadcast hold: 1 = hold, 0 = accumulate
- `pe_carry_en`  out  COLS  per-column result-carry select
- `out_valid`  out  1  result column available
- `out_ready`  in  1  downstream accepts the column
- `out_col`  out  clog2(COLS)  index of the column currently presented
- `perf_cycles`  out  32  job cycle count (see Configuration)

## Operation
States are IDLE, CLEAR, FEED, DRAIN, READOUT and DONE.

- **IDLE**
  - Outputs: `pe_load`=1, everything else 0.
  - `start`=1 latches `k_len` and moves to CLEAR.
- **CLEAR** (1 cycle)
  - Outputs: `pe_clear`=1, `pe_load`=0.
  - Next state: FEED, or DRAIN if `k_len`=0.
- **FEED** (`k_len` cycles)
  - Outputs: `rd_en`=1, `pe_load`=0.
  - `rd_addr` runs 0, 1, …, `k_len`−1.
- **DRAIN** (ROWS+COLS−1 cycles)
  - Outputs: `rd_en`=0, `pe_load`=0.
  - `op_valid` falls 1 cycle into DRAIN, so the array accumulates zeros while the skew flushes.
  - After the last DRAIN cycle, go to READOUT.
- **READOUT**
  - Outputs: `pe_load`=1, `out_valid`=1.
  - `out_col`=c, starting at c=0.
  - `pe_carry_en[j]` = (j > c), a thermometer mask, so column c's accumulator reaches the output at column COLS−1.
  - c advances only on `out_valid`&&`out_ready`.
  - After c=COLS−1 transfers, go to DONE.
- **DONE** (1 cycle)
  - Outputs: `done`=1, `pe_load`=1.
  - Next state: IDLE.

Arithmetic and boundary rules:
- Address and column counters are widthed exactly; `rd_addr` never reaches `k_len`.
- `k_len` > KMAX is clamped to KMAX.
- `start` while busy is ignored; no queueing.
- `start` in the DONE cycle is ignored.
- `k_len`=0: the job runs CLEAR, then DRAIN (with no FEED), then READOUT, and produces all-zero columns.
- `out_ready` low holds the presented column and keeps `pe_load`=1, so the accumulators are frozen.
- Reset at any point forces IDLE and IDLE output values on the next edge.

## Timing
- Reset values: `pe_load`=1; every other output 0, including `perf_cycles`.
- Example schedule, with `start` sampled in cycle 0:

| Phase | Cycles |
|---|---|
| CLEAR | 1 |
| FEED | 2 … k+1 |
| DRAIN | k+2 … k+ROWS+COLS |
| first `out_valid` | k+ROWS+COLS+1 |

- With `out_ready` held at 1:
  - columns transfer on consecutive cycles;
  - `done` occurs at cycle k+ROWS+COLS+COLS+1;
  - `busy` is high for exactly that window, starting at cycle 1.
- Every output is registered.
- `op_valid` equals `rd_en` delayed by exactly 1 cycle.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined:
  - `perf_cycles` counts from CLEAR through DONE inclusive;
  - it holds that value until the next accepted `start`, then restarts at 1;
  - it saturates at 2^32−1.
- `SYSTOLIC_CTRL_PERF_EN` not defined: `perf_cycles` is tied to 0 and no counter is built.

## Structure
- Package `systolic_pkg` holds:
  - `ctrl_state_t`, the state enum;
  - the `K_W` width constant;
  - a `drain_cycles(ROWS,COLS)` constant function.
- One sub-module, `carry_mask_gen`, which is combinational: column index c → COLS-bit thermometer mask with bits j>c set.
- The FSM, counters, handshake and perf counter stay in `systolic_ctrl`.

## Test plan
Expected cycle numbers below use default parameters (ROWS=COLS=4) and count from the `start` sample cycle.

1. **Basic job.** ROWS=COLS=4, `k_len`=8, `out_ready`=1.
   - `rd_addr` 0..7 in cycles 2..9.
   - `out_valid` in cycles 17..20 with `pe_carry_en` = 1110, 1100, 1000, 0000.
   - `done` in cycle 21.
2. **Backpressure.**
   - `out_ready`=0 for 5 cycles at column 1: `out_col` stays 1, `pe_load` stays 1, `pe_carry_en` stays 1100.
   - `done` is delayed by exactly 5 cycles.
3. **Zero length.** `k_len`=0:
   - `rd_en` never asserts;
   - DRAIN lasts 7 cycles;
   - 4 columns are emitted;
   - `done` in cycle 13.
4. **Busy start.** `start` pulsed in the FEED and DONE cycles:
   - both are ignored;
   - a `start` 1 cycle after DONE (in IDLE) is accepted.
5. **Mid-operation reset.** `reset` in cycle 5 of FEED: the next cycle shows IDLE outputs (`pe_load`=1, `busy`=0, `rd_en`=0).
6. **Perf counter.** `SYSTOLIC_CTRL_PERF_EN` defined, `k_len`=8, no stalls: `perf_cycles`=21 after `done`, held until the next `start`.
